// File: rtl/irq_pkg.sv
// Shared constants for the machine-mode interrupt controller: CSR addresses,
// interrupt bit positions, mcause encodings and FSM state encoding.
package irq_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // Interrupt bit positions, shared by mip and mie.
    localparam int BIT_MSI = 3;
    localparam int BIT_MTI = 7;
    localparam int BIT_MEI = 11;

    // mstatus bit positions.
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] IRQ_MASK = 32'h0000_0888;

    localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;
    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_TRAP = 2'd2
    } irq_state_e;

    // Fixed priority MEI > MSI > MTI over the enabled-and-pending vector.
    function automatic logic [31:0] irq_pick_cause(input logic [31:0] active);
        logic [31:0] cause;
        cause = '0;
        if (active[BIT_MEI])
            cause = CAUSE_MEI;
        else if (active[BIT_MSI])
            cause = CAUSE_MSI;
        else if (active[BIT_MTI])
            cause = CAUSE_MTI;
        return cause;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Synchronizer flop chain for an asynchronous single-bit input.
// SYNC_STAGES must be 2 or 3.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the async input through the chain; cleared by reset.
    always_ff @(posedge clk) begin
        if (rst)
            sync_q <= '0;
        else
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// Machine-mode interrupt controller between the CLINT and the core trap logic.
// Holds mip/mie/mstatus.MIE/MPIE, arbitrates MEI > MSI > MTI and presents one
// trap request until acknowledged. MIE/MPIE stack on ack and unstack on mret.
//
// Build option: define IRQ_EXT_EDGE_EN to make mip.MEIP a sticky, rising-edge
// triggered bit (cleared by writing mip bit 11 = 0 or by acking an MEI trap).
// Without it MEIP follows the synchronized meip_i level.
//
// state | meaning
// IDLE  | no trap outstanding; raise a request when take is true
// REQ   | request held on irq_req_o/irq_cause_o until irq_ack_i
// TRAP  | core is in the handler; wait for mret_i or a nested take
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CAUSE_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               msip_i,
    input  logic               mtip_i,
    input  logic               meip_i,
    input  logic               csr_en,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               irq_req_o,
    output logic [CAUSE_W-1:0] irq_cause_o,
    input  logic               irq_ack_i,
    input  logic               mret_i,
    output logic               irq_pending_o
);

    logic        meip_sync;
    logic        msip_q;
    logic        mtip_q;
    logic        meip_q;
    logic [31:0] mie_q;
    logic        mstatus_mie_q;
    logic        mstatus_mpie_q;
    irq_state_e  state_q;

    logic [31:0] mip_w;
    logic [31:0] mstatus_w;
    logic [31:0] active_w;
    logic [31:0] rd_data_w;
    logic        take_w;
    logic        csr_wr_w;

    assign csr_wr_w = csr_en & csr_we;

    irq_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_meip_sync (
        .clk (clk),
        .rst (rst),
        .d_i (meip_i),
        .q_o (meip_sync)
    );

    // CLINT lines are already synchronous; register them straight into mip.
    always_ff @(posedge clk) begin
        if (rst) begin
            msip_q <= 1'b0;
            mtip_q <= 1'b0;
        end else begin
            msip_q <= msip_i;
            mtip_q <= mtip_i;
        end
    end

`ifdef IRQ_EXT_EDGE_EN
    logic meip_sync_prev_q;
    logic meip_d;
    logic meip_rise_w;
    logic meip_clr_w;

    assign meip_rise_w = meip_sync & ~meip_sync_prev_q;
    assign meip_clr_w  = (csr_wr_w && (csr_addr == CSR_MIP) && !csr_wdata[BIT_MEI])
                       || ((state_q == ST_REQ) && irq_ack_i
                           && (irq_cause_o == CAUSE_W'(CAUSE_MEI)));
    // A fresh edge beats a simultaneous clear so no event is lost.
    assign meip_d      = meip_rise_w | (meip_q & ~meip_clr_w);

    // Sticky external pending bit set on a synchronized rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meip_sync_prev_q <= 1'b0;
            meip_q           <= 1'b0;
        end else begin
            meip_sync_prev_q <= meip_sync;
            meip_q           <= meip_d;
        end
    end
`else
    // External pending bit follows the synchronized level.
    always_ff @(posedge clk) begin
        if (rst)
            meip_q <= 1'b0;
        else
            meip_q <= meip_sync;
    end
`endif

    // Assemble the architectural views of mip and mstatus.
    always_comb begin
        mip_w                       = '0;
        mip_w[BIT_MSI]              = msip_q;
        mip_w[BIT_MTI]              = mtip_q;
        mip_w[BIT_MEI]              = meip_q;
        mstatus_w                   = '0;
        mstatus_w[MSTATUS_MIE]      = mstatus_mie_q;
        mstatus_w[MSTATUS_MPIE]     = mstatus_mpie_q;
    end

    assign active_w      = mip_w & mie_q;
    assign take_w        = mstatus_mie_q & (|active_w);
    assign irq_pending_o = |active_w;

    // mie holds only the three implemented enable bits.
    always_ff @(posedge clk) begin
        if (rst)
            mie_q <= '0;
        else if (csr_wr_w && (csr_addr == CSR_MIE))
            mie_q <= csr_wdata & IRQ_MASK;
    end

    // CSR read mux.
    always_comb begin
        rd_data_w = '0;
        case (csr_addr)
            CSR_MSTATUS: rd_data_w = mstatus_w;
            CSR_MIE:     rd_data_w = mie_q;
            CSR_MIP:     rd_data_w = mip_w;
            default:     rd_data_w = '0;
        endcase
    end

    // Registered read data, held between reads.
    always_ff @(posedge clk) begin
        if (rst)
            csr_rdata <= '0;
        else if (csr_en && !csr_we)
            csr_rdata <= rd_data_w;
    end

    // Trap FSM with MIE/MPIE stacking; FSM updates are written after the CSR
    // write so they take precedence when both hit mstatus in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            irq_req_o      <= 1'b0;
            irq_cause_o    <= '0;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
        end else begin
            if (csr_wr_w && (csr_addr == CSR_MSTATUS)) begin
                mstatus_mie_q  <= csr_wdata[MSTATUS_MIE];
                mstatus_mpie_q <= csr_wdata[MSTATUS_MPIE];
            end
            case (state_q)
                ST_IDLE: begin
                    if (mret_i) begin
                        mstatus_mie_q  <= mstatus_mpie_q;
                        mstatus_mpie_q <= 1'b1;
                    end
                    if (take_w) begin
                        state_q     <= ST_REQ;
                        irq_req_o   <= 1'b1;
                        irq_cause_o <= CAUSE_W'(irq_pick_cause(active_w));
                    end
                end
                ST_REQ: begin
                    if (irq_ack_i) begin
                        mstatus_mpie_q <= mstatus_mie_q;
                        mstatus_mie_q  <= 1'b0;
                        irq_req_o      <= 1'b0;
                        state_q        <= ST_TRAP;
                    end
                end
                ST_TRAP: begin
                    if (mret_i) begin
                        mstatus_mie_q  <= mstatus_mpie_q;
                        mstatus_mpie_q <= 1'b1;
                        state_q        <= ST_IDLE;
                    end else if (take_w) begin
                        state_q     <= ST_REQ;
                        irq_req_o   <= 1'b1;
                        irq_cause_o <= CAUSE_W'(irq_pick_cause(active_w));
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    irq_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl. Expected CSR read data and trap causes are
// queued when stimulus is issued; a monitor pops and compares them whenever
// read data returns or a new trap request rises.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        msip_i = 1'b0;
    logic        mtip_i = 1'b0;
    logic        meip_i = 1'b0;
    logic        csr_en = 1'b0;
    logic        csr_we = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [31:0] csr_rdata;
    logic        irq_req_o;
    logic [31:0] irq_cause_o;
    logic        irq_ack_i = 1'b0;
    logic        mret_i = 1'b0;
    logic        irq_pending_o;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] rd_q[$];
    logic [31:0] irq_q[$];
    logic        rd_v = 1'b0;
    logic        req_prev = 1'b0;

    always #5 clk = ~clk;

    irq_ctrl #(
        .SYNC_STAGES(2),
        .CAUSE_W    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .msip_i       (msip_i),
        .mtip_i       (mtip_i),
        .meip_i       (meip_i),
        .csr_en       (csr_en),
        .csr_we       (csr_we),
        .csr_addr     (csr_addr),
        .csr_wdata    (csr_wdata),
        .csr_rdata    (csr_rdata),
        .irq_req_o    (irq_req_o),
        .irq_cause_o  (irq_cause_o),
        .irq_ack_i    (irq_ack_i),
        .mret_i       (mret_i),
        .irq_pending_o(irq_pending_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // A read accepted at this edge returns data that is valid until the next edge.
    always @(posedge clk) rd_v <= csr_en && !csr_we && !rst;

    always @(negedge clk) begin
        if (rd_v) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL csr_rdata: unexpected read data 0x%08h, none queued", csr_rdata);
            end else begin
                check("csr_rdata", csr_rdata, rd_q.pop_front());
            end
        end
        if (irq_req_o && !req_prev) begin
            if (irq_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL irq_cause: unexpected request cause 0x%08h, none queued", irq_cause_o);
            end else begin
                check("irq_cause", irq_cause_o, irq_q.pop_front());
            end
        end
        req_prev = irq_req_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] addr, input logic [31:0] data);
        csr_en    = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = addr;
        csr_wdata = data;
        tick();
        csr_en    = 1'b0;
        csr_we    = 1'b0;
    endtask

    task automatic csr_rd(input logic [11:0] addr, input logic [31:0] exp);
        rd_q.push_back(exp);
        csr_en   = 1'b1;
        csr_we   = 1'b0;
        csr_addr = addr;
        tick();
        csr_en   = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!irq_req_o && n < 20) begin
            tick();
            n++;
        end
        check(name, {31'b0, irq_req_o}, 32'd1);
    endtask

    task automatic ack();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
    endtask

    task automatic mret();
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_req", {31'b0, irq_req_o}, 32'd0);
        check("rst_cause", irq_cause_o, 32'd0);
        check("rst_rdata", csr_rdata, 32'd0);
        check("rst_pending", {31'b0, irq_pending_o}, 32'd0);
        rst = 1'b0;
        tick();

        // CSR map: masking, read-only mip, unmapped address
        csr_wr(12'h304, 32'hFFFF_FFFF);
        csr_rd(12'h304, 32'h0000_0888);
        csr_wr(12'h300, 32'hFFFF_FFFF);
        csr_rd(12'h300, 32'h0000_0088);
        csr_wr(12'h300, 32'h0);
        csr_wr(12'h344, 32'hFFFF_FFFF);
        csr_rd(12'h344, 32'h0);
        csr_wr(12'h305, 32'hFFFF_FFFF);
        csr_rd(12'h305, 32'h0);

        // Timer interrupt: latency, hold while source drops, stacking on ack
        csr_wr(12'h304, 32'h88);
        csr_wr(12'h300, 32'h8);
        csr_rd(12'h300, 32'h8);
        irq_q.push_back(32'h8000_0007);
        mtip_i = 1'b1;
        tick();
        check("mti_latency_early", {31'b0, irq_req_o}, 32'd0);
        tick();
        check("mti_latency", {31'b0, irq_req_o}, 32'd1);
        mtip_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("req_hold", {31'b0, irq_req_o}, 32'd1);
            check("cause_hold", irq_cause_o, 32'h8000_0007);
        end
        ack();
        check("ack_drops_req", {31'b0, irq_req_o}, 32'd0);
        csr_rd(12'h300, 32'h80);
        mret();
        csr_rd(12'h300, 32'h88);

        // MSI beats MEI while MEI is still in the synchronizer
        csr_wr(12'h304, 32'h888);
        irq_q.push_back(32'h8000_0003);
        irq_q.push_back(32'h8000_000B);
        msip_i = 1'b1;
        meip_i = 1'b1;
        wait_req("req_msi");
        msip_i = 1'b0;
        ack();
        repeat (3) tick();
        mret();
        wait_req("req_mei");
        meip_i = 1'b0;
        ack();
        repeat (5) tick();
        mret();
        tick();
        check("no_spurious_req", {31'b0, irq_req_o}, 32'd0);

        // Nested trap, then MIE/MPIE unstacking on two mrets
        irq_q.push_back(32'h8000_0007);
        mtip_i = 1'b1;
        wait_req("req_mti2");
        mtip_i = 1'b0;
        ack();
        repeat (3) tick();
        msip_i = 1'b1;
        tick();
        tick();
        check("nested_blocked", {31'b0, irq_req_o}, 32'd0);
        check("wfi_pending", {31'b0, irq_pending_o}, 32'd1);
        irq_q.push_back(32'h8000_0003);
        csr_wr(12'h300, 32'h8);
        wait_req("req_nested");
        msip_i = 1'b0;
        ack();
        csr_rd(12'h300, 32'h80);
        repeat (3) tick();
        csr_wr(12'h300, 32'h0);
        mret();
        csr_rd(12'h300, 32'h80);
        mret();
        csr_rd(12'h300, 32'h88);

        // mret coinciding with an mstatus write: the restore wins
        mret_i = 1'b1;
        csr_wr(12'h300, 32'h0);
        mret_i = 1'b0;
        csr_rd(12'h300, 32'h88);

        // ack outside REQ is ignored
        ack();
        csr_rd(12'h300, 32'h88);

        // Reset during REQ aborts the request and clears the CSRs
        irq_q.push_back(32'h8000_0007);
        mtip_i = 1'b1;
        wait_req("req_before_rst");
        mtip_i = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_req_abort", {31'b0, irq_req_o}, 32'd0);
        check("rst_rdata_clr", csr_rdata, 32'd0);
        check("rst_cause_clr", irq_cause_o, 32'd0);
        rst = 1'b0;
        csr_rd(12'h300, 32'h0);
        csr_rd(12'h304, 32'h0);
        csr_rd(12'h344, 32'h0);
        check("rst_pending_clr", {31'b0, irq_pending_o}, 32'd0);

`ifdef IRQ_EXT_EDGE_EN
        // Sticky MEIP from a single-cycle pulse
        meip_i = 1'b1;
        tick();
        meip_i = 1'b0;
        repeat (5) tick();
        csr_rd(12'h344, 32'h800);
        csr_rd(12'h344, 32'h800);
        csr_wr(12'h344, 32'h800);
        csr_rd(12'h344, 32'h800);
        csr_wr(12'h344, 32'h0);
        csr_rd(12'h344, 32'h0);
`else
        // Level-following MEIP; mip writes have no effect
        meip_i = 1'b1;
        repeat (4) tick();
        csr_rd(12'h344, 32'h800);
        csr_wr(12'h344, 32'h0);
        csr_rd(12'h344, 32'h800);
        meip_i = 1'b0;
        repeat (4) tick();
        csr_rd(12'h344, 32'h0);
`endif

        repeat (3) tick();
        check("irq_queue_drained", rd_q.size() + irq_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
